rat_control_fsm_v2: RTL and testbench

Parametrised multi-cycle control unit for the RAT CPU. It sequences fetch, execute, interrupt entry and stretched I/O strobes, and decodes the branch, call/return, stack, interrupt-flag, EXOR, MOV, IN and OUT instructions. It drives the PC, register file, ALU, SP, scratch RAM, flags and I/O strobe. It supports slow program memory (fetch wait states), slow peripherals (multi-cycle IO_STRB) and reports unrecognised opcodes.

---
 rtl/rat_control_fsm_v2.sv | 265 ++++++++++++++++++++++++++
 tb/tb_rat_control_fsm_v2.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rat_control_fsm_v2.sv
// ---------------------------------------------------------------------------
// rat_control_fsm_v2
// Multi-cycle control unit for the RAT CPU. Sequences instruction fetch
// (with optional wait states for slow program memory), a single execute
// cycle, an optional stretched I/O strobe for slow peripherals and
// interrupt entry. Decodes branch, call/return, stack, interrupt-flag,
// EXOR, MOV, IN and OUT instructions and flags unrecognised opcodes.
//
// Parameters
//   FETCH_WAIT     : extra FETCH cycles before PC_INC (0..7)
//   IO_STRB_CYCLES : width of the OUT strobe in cycles (1..8)
//
// Ports
//   CLK, RESET              : clock (rising edge), synchronous active-high reset
//   C, Z                    : carry / zero flags
//   INT                     : interrupt request (already masked)
//   OPCODE_HI_5, OPCODE_LO_2: instruction bits [17:13] and [1:0]
//   PC_*                    : program counter control
//   ALU_*                   : ALU operand / operation select
//   RF_*                    : register file write and source select
//   SP_*                    : stack pointer increment / decrement
//   SCR_*                   : scratch RAM write, address and data select
//   FLG_*                   : flag register and shadow flag control
//   I_SET, I_CLR            : interrupt enable set / clear
//   RST                     : datapath reset
//   IO_STRB                 : output strobe
//   ILL_OP                  : unrecognised opcode seen in EXEC
// All outputs are combinational from state, counter, opcode, C and Z.
// ---------------------------------------------------------------------------
module rat_control_fsm_v2 #(
    parameter int FETCH_WAIT     = 0,
    parameter int IO_STRB_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       C,
    input  logic       Z,
    input  logic       INT,
    input  logic [4:0] OPCODE_HI_5,
    input  logic [1:0] OPCODE_LO_2,
    output logic       I_SET,
    output logic       I_CLR,
    output logic       PC_LD,
    output logic       PC_INC,
    output logic [1:0] PC_MUX_SEL,
    output logic       ALU_OPY_SEL,
    output logic [3:0] ALU_SEL,
    output logic       RF_WR,
    output logic [1:0] RF_WR_SEL,
    output logic       SP_INCR,
    output logic       SP_DECR,
    output logic       SCR_WE,
    output logic [1:0] SCR_ADDR_SEL,
    output logic       SCR_DATA_SEL,
    output logic       FLG_C_CLR,
    output logic       FLG_C_LD,
    output logic       FLG_Z_LD,
    output logic       FLG_LD_SEL,
    output logic       FLG_SHAD_LD,
    output logic       RST,
    output logic       IO_STRB,
    output logic       ILL_OP
);

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_EXEC    = 3'd2,
        ST_IO_HOLD = 3'd3,
        ST_INTR    = 3'd4
    } state_t;

    // Terminal counter values for the fetch wait and the stretched strobe.
    localparam logic [2:0] FETCH_LAST = 3'(FETCH_WAIT);
    localparam logic [2:0] IO_LAST    = 3'(IO_STRB_CYCLES - 1);
    localparam logic       IO_STRETCH = (IO_STRB_CYCLES > 1) ? 1'b1 : 1'b0;

    state_t     r_ps;
    state_t     w_ns;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic [6:0] w_opcode;
    logic       w_out_op;

    assign w_opcode = {OPCODE_HI_5, OPCODE_LO_2};

    // State and counter register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ps  <= ST_INIT;
            r_cnt <= 3'd0;
        end else begin
            r_ps  <= w_ns;
            r_cnt <= w_cnt_nxt;
        end
    end

    // Next-state, counter and control-output decode.
    always_comb begin
        w_ns         = r_ps;
        w_cnt_nxt    = r_cnt;
        w_out_op     = 1'b0;
        I_SET        = 1'b0;
        I_CLR        = 1'b0;
        PC_LD        = 1'b0;
        PC_INC       = 1'b0;
        PC_MUX_SEL   = 2'b00;
        ALU_OPY_SEL  = 1'b0;
        ALU_SEL      = 4'b0000;
        RF_WR        = 1'b0;
        RF_WR_SEL    = 2'b00;
        SP_INCR      = 1'b0;
        SP_DECR      = 1'b0;
        SCR_WE       = 1'b0;
        SCR_ADDR_SEL = 2'b00;
        SCR_DATA_SEL = 1'b0;
        FLG_C_CLR    = 1'b0;
        FLG_C_LD     = 1'b0;
        FLG_Z_LD     = 1'b0;
        FLG_LD_SEL   = 1'b0;
        FLG_SHAD_LD  = 1'b0;
        RST          = 1'b0;
        IO_STRB      = 1'b0;
        ILL_OP       = 1'b0;

        case (r_ps)
            ST_INIT: begin
                RST       = 1'b1;
                w_ns      = ST_FETCH;
                w_cnt_nxt = 3'd0;
            end

            ST_FETCH: begin
                if (r_cnt == FETCH_LAST) begin
                    PC_INC    = 1'b1;
                    w_ns      = ST_EXEC;
                    w_cnt_nxt = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end

            ST_EXEC: begin
                casez (w_opcode)
                    7'b0010000: PC_LD = 1'b1;           // BRN
                    7'b0010010: PC_LD = Z;              // BREQ
                    7'b0010011: PC_LD = ~Z;             // BRNE
                    7'b0010100: PC_LD = C;              // BRCS
                    7'b0010101: PC_LD = ~C;             // BRCC
                    7'b0010001: begin                   // CALL: push PC at SP-1
                        PC_LD        = 1'b1;
                        SCR_WE       = 1'b1;
                        SCR_DATA_SEL = 1'b1;
                        SCR_ADDR_SEL = 2'b11;
                        SP_DECR      = 1'b1;
                    end
                    7'b0110010: begin                   // RET: pop PC from SP
                        PC_LD        = 1'b1;
                        PC_MUX_SEL   = 2'b01;
                        SCR_ADDR_SEL = 2'b10;
                        SP_INCR      = 1'b1;
                    end
                    7'b011011?: begin                   // RETID / RETIE
                        PC_LD        = 1'b1;
                        PC_MUX_SEL   = 2'b01;
                        SCR_ADDR_SEL = 2'b10;
                        SP_INCR      = 1'b1;
                        FLG_LD_SEL   = 1'b1;
                        FLG_C_LD     = 1'b1;
                        FLG_Z_LD     = 1'b1;
                        I_SET        = OPCODE_LO_2[0];
                        I_CLR        = ~OPCODE_LO_2[0];
                    end
                    7'b0110100: I_SET = 1'b1;           // SEI
                    7'b0110101: I_CLR = 1'b1;           // CLI
                    7'b0100101: begin                   // PUSH
                        SCR_WE       = 1'b1;
                        SCR_ADDR_SEL = 2'b11;
                        SP_DECR      = 1'b1;
                    end
                    7'b0100110: begin                   // POP
                        RF_WR        = 1'b1;
                        RF_WR_SEL    = 2'b01;
                        SCR_ADDR_SEL = 2'b10;
                        SP_INCR      = 1'b1;
                    end
                    7'b0000010: begin                   // EXOR reg,reg
                        RF_WR     = 1'b1;
                        ALU_SEL   = 4'b0111;
                        FLG_C_CLR = 1'b1;
                        FLG_Z_LD  = 1'b1;
                    end
                    7'b10010??: begin                   // EXOR reg,imm
                        RF_WR       = 1'b1;
                        ALU_SEL     = 4'b0111;
                        ALU_OPY_SEL = 1'b1;
                        FLG_C_CLR   = 1'b1;
                        FLG_Z_LD    = 1'b1;
                    end
                    7'b0001001: begin                   // MOV reg,reg
                        RF_WR   = 1'b1;
                        ALU_SEL = 4'b1110;
                    end
                    7'b11011??: begin                   // MOV reg,imm
                        RF_WR       = 1'b1;
                        ALU_SEL     = 4'b1110;
                        ALU_OPY_SEL = 1'b1;
                    end
                    7'b11001??: begin                   // IN
                        RF_WR     = 1'b1;
                        RF_WR_SEL = 2'b11;
                    end
                    7'b11010??: begin                   // OUT
                        IO_STRB  = 1'b1;
                        w_out_op = 1'b1;
                    end
                    default: ILL_OP = 1'b1;
                endcase

                // A stretched OUT defers the interrupt check to the last
                // IO_HOLD cycle so the strobe is never cut short.
                if (w_out_op && IO_STRETCH) begin
                    w_ns      = ST_IO_HOLD;
                    w_cnt_nxt = 3'd1;
                end else if (INT) begin
                    w_ns      = ST_INTR;
                    w_cnt_nxt = 3'd0;
                end else begin
                    w_ns      = ST_FETCH;
                    w_cnt_nxt = 3'd0;
                end
            end

            ST_IO_HOLD: begin
                IO_STRB = 1'b1;
                if (r_cnt == IO_LAST) begin
                    w_ns      = INT ? ST_INTR : ST_FETCH;
                    w_cnt_nxt = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end

            ST_INTR: begin
                // Push PC at SP-1, save flags, mask interrupts, jump to 0x3FF.
                PC_LD        = 1'b1;
                PC_MUX_SEL   = 2'b10;
                SCR_WE       = 1'b1;
                SCR_DATA_SEL = 1'b1;
                SCR_ADDR_SEL = 2'b11;
                SP_DECR      = 1'b1;
                FLG_SHAD_LD  = 1'b1;
                I_CLR        = 1'b1;
                w_ns         = ST_FETCH;
                w_cnt_nxt    = 3'd0;
            end

            default: begin
                w_ns      = ST_INIT;
                w_cnt_nxt = 3'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_rat_control_fsm_v2.sv
// ---------------------------------------------------------------------------
// Testbench for rat_control_fsm_v2. Instance A uses default parameters
// (no fetch wait, 1-cycle strobe) and runs a decode table; instance B uses
// FETCH_WAIT=3, IO_STRB_CYCLES=4 for wait-state, stretched strobe and reset
// abort sequences. Expected output words are queued with each stimulus
// cycle and compared at the following falling edge.
// ---------------------------------------------------------------------------
module tb_rat_control_fsm_v2;

    // Output word layout (MSB first).
    localparam logic [27:0] B_I_SET   = 28'd1 << 27;
    localparam logic [27:0] B_I_CLR   = 28'd1 << 26;
    localparam logic [27:0] B_PC_LD   = 28'd1 << 25;
    localparam logic [27:0] B_PC_INC  = 28'd1 << 24;
    localparam logic [27:0] B_PCM_01  = 28'd1 << 22;
    localparam logic [27:0] B_PCM_10  = 28'd2 << 22;
    localparam logic [27:0] B_OPY     = 28'd1 << 21;
    localparam logic [27:0] B_ALU_XOR = 28'd7 << 17;
    localparam logic [27:0] B_ALU_MOV = 28'd14 << 17;
    localparam logic [27:0] B_RF_WR   = 28'd1 << 16;
    localparam logic [27:0] B_RFS_01  = 28'd1 << 14;
    localparam logic [27:0] B_RFS_11  = 28'd3 << 14;
    localparam logic [27:0] B_SP_INC  = 28'd1 << 13;
    localparam logic [27:0] B_SP_DEC  = 28'd1 << 12;
    localparam logic [27:0] B_SCR_WE  = 28'd1 << 11;
    localparam logic [27:0] B_SA_10   = 28'd2 << 9;
    localparam logic [27:0] B_SA_11   = 28'd3 << 9;
    localparam logic [27:0] B_SD_PC   = 28'd1 << 8;
    localparam logic [27:0] B_C_CLR   = 28'd1 << 7;
    localparam logic [27:0] B_C_LD    = 28'd1 << 6;
    localparam logic [27:0] B_Z_LD    = 28'd1 << 5;
    localparam logic [27:0] B_LD_SEL  = 28'd1 << 4;
    localparam logic [27:0] B_SHAD    = 28'd1 << 3;
    localparam logic [27:0] B_RST     = 28'd1 << 2;
    localparam logic [27:0] B_IO      = 28'd1 << 1;
    localparam logic [27:0] B_ILL     = 28'd1;
    localparam logic [27:0] B_NONE    = 28'd0;

    localparam logic [27:0] V_RET  = B_PC_LD | B_PCM_01 | B_SA_10 | B_SP_INC;
    localparam logic [27:0] V_RETI = V_RET | B_LD_SEL | B_C_LD | B_Z_LD;
    localparam logic [27:0] V_INTR = B_PC_LD | B_PCM_10 | B_SCR_WE | B_SD_PC |
                                     B_SA_11 | B_SP_DEC | B_SHAD | B_I_CLR;

    typedef struct {
        logic [4:0]  hi;
        logic [1:0]  lo;
        logic        c;
        logic        z;
        logic [27:0] exp;
        string       tag;
    } vec_t;

    typedef struct {
        logic [27:0] exp;
        string       tag;
    } sb_t;

    logic CLK;
    int   n_checks;
    int   n_fail;

    logic       a_RESET, a_C, a_Z, a_INT;
    logic [4:0] a_HI;
    logic [1:0] a_LO;
    wire [27:0] a_out;

    logic       b_RESET, b_C, b_Z, b_INT;
    logic [4:0] b_HI;
    logic [1:0] b_LO;
    wire [27:0] b_out;

    vec_t vecs[$];
    sb_t  q_a[$];
    sb_t  q_b[$];
    sb_t  ea;
    sb_t  eb;

    rat_control_fsm_v2 #(.FETCH_WAIT(0), .IO_STRB_CYCLES(1)) dut_a (
        .CLK(CLK), .RESET(a_RESET), .C(a_C), .Z(a_Z), .INT(a_INT),
        .OPCODE_HI_5(a_HI), .OPCODE_LO_2(a_LO),
        .I_SET(a_out[27]), .I_CLR(a_out[26]), .PC_LD(a_out[25]),
        .PC_INC(a_out[24]), .PC_MUX_SEL(a_out[23:22]),
        .ALU_OPY_SEL(a_out[21]), .ALU_SEL(a_out[20:17]), .RF_WR(a_out[16]),
        .RF_WR_SEL(a_out[15:14]), .SP_INCR(a_out[13]), .SP_DECR(a_out[12]),
        .SCR_WE(a_out[11]), .SCR_ADDR_SEL(a_out[10:9]),
        .SCR_DATA_SEL(a_out[8]), .FLG_C_CLR(a_out[7]), .FLG_C_LD(a_out[6]),
        .FLG_Z_LD(a_out[5]), .FLG_LD_SEL(a_out[4]), .FLG_SHAD_LD(a_out[3]),
        .RST(a_out[2]), .IO_STRB(a_out[1]), .ILL_OP(a_out[0])
    );

    rat_control_fsm_v2 #(.FETCH_WAIT(3), .IO_STRB_CYCLES(4)) dut_b (
        .CLK(CLK), .RESET(b_RESET), .C(b_C), .Z(b_Z), .INT(b_INT),
        .OPCODE_HI_5(b_HI), .OPCODE_LO_2(b_LO),
        .I_SET(b_out[27]), .I_CLR(b_out[26]), .PC_LD(b_out[25]),
        .PC_INC(b_out[24]), .PC_MUX_SEL(b_out[23:22]),
        .ALU_OPY_SEL(b_out[21]), .ALU_SEL(b_out[20:17]), .RF_WR(b_out[16]),
        .RF_WR_SEL(b_out[15:14]), .SP_INCR(b_out[13]), .SP_DECR(b_out[12]),
        .SCR_WE(b_out[11]), .SCR_ADDR_SEL(b_out[10:9]),
        .SCR_DATA_SEL(b_out[8]), .FLG_C_CLR(b_out[7]), .FLG_C_LD(b_out[6]),
        .FLG_Z_LD(b_out[5]), .FLG_LD_SEL(b_out[4]), .FLG_SHAD_LD(b_out[3]),
        .RST(b_out[2]), .IO_STRB(b_out[1]), .ILL_OP(b_out[0])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scoreboard for instance A: one expected word per clock cycle.
    always @(negedge CLK) begin
        if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            n_checks++;
            if (a_out !== ea.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", ea.tag, a_out, ea.exp);
            end
        end
    end

    // Scoreboard for instance B.
    always @(negedge CLK) begin
        if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            n_checks++;
            if (b_out !== eb.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", eb.tag, b_out, eb.exp);
            end
        end
    end

    task automatic add(input logic [4:0] hi, input logic [1:0] lo, input logic c,
                       input logic z, input logic [27:0] exp, input string tag);
        vec_t v;
        v.hi = hi; v.lo = lo; v.c = c; v.z = z; v.exp = exp; v.tag = tag;
        vecs.push_back(v);
    endtask

    // Queue the expected word for the current cycle, then advance one clock.
    task automatic cyc_a(input logic [27:0] e, input string t);
        sb_t s;
        s.exp = e; s.tag = t;
        q_a.push_back(s);
        @(posedge CLK);
        #1;
    endtask

    task automatic cyc_b(input logic [27:0] e, input string t);
        sb_t s;
        s.exp = e; s.tag = t;
        q_b.push_back(s);
        @(posedge CLK);
        #1;
    endtask

    // Four-cycle fetch of instance B: three wait cycles then PC_INC.
    task automatic fetch_b(input string t);
        cyc_b(B_NONE, {t, "_w0"});
        cyc_b(B_NONE, {t, "_w1"});
        cyc_b(B_NONE, {t, "_w2"});
        cyc_b(B_PC_INC, {t, "_inc"});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        a_RESET = 1'b1; a_C = 1'b0; a_Z = 1'b0; a_INT = 1'b0; a_HI = 5'd0; a_LO = 2'd0;
        b_RESET = 1'b1; b_C = 1'b0; b_Z = 1'b0; b_INT = 1'b0; b_HI = 5'd0; b_LO = 2'd0;

        add(5'b11111, 2'b11, 1'b0, 1'b0, B_ILL, "ill_1111111_a");
        add(5'b00100, 2'b00, 1'b0, 1'b0, B_PC_LD, "brn");
        add(5'b00100, 2'b10, 1'b0, 1'b0, B_NONE, "breq_z0");
        add(5'b00100, 2'b10, 1'b0, 1'b1, B_PC_LD, "breq_z1");
        add(5'b00100, 2'b11, 1'b0, 1'b1, B_NONE, "brne_z1");
        add(5'b00101, 2'b00, 1'b1, 1'b0, B_PC_LD, "brcs_c1");
        add(5'b00101, 2'b01, 1'b1, 1'b0, B_NONE, "brcc_c1");
        add(5'b00101, 2'b01, 1'b0, 1'b0, B_PC_LD, "brcc_c0");
        add(5'b00100, 2'b01, 1'b0, 1'b0, B_PC_LD | B_SCR_WE | B_SD_PC | B_SA_11 | B_SP_DEC, "call");
        add(5'b01100, 2'b10, 1'b0, 1'b0, V_RET, "ret");
        add(5'b01101, 2'b10, 1'b0, 1'b0, V_RETI | B_I_CLR, "retid");
        add(5'b01101, 2'b00, 1'b0, 1'b0, B_I_SET, "sei");
        add(5'b01101, 2'b01, 1'b0, 1'b0, B_I_CLR, "cli");
        add(5'b01001, 2'b01, 1'b0, 1'b0, B_SCR_WE | B_SA_11 | B_SP_DEC, "push");
        add(5'b01001, 2'b10, 1'b0, 1'b0, B_RF_WR | B_RFS_01 | B_SA_10 | B_SP_INC, "pop");
        add(5'b00000, 2'b10, 1'b0, 1'b0, B_RF_WR | B_ALU_XOR | B_C_CLR | B_Z_LD, "exor_reg");
        add(5'b10010, 2'b11, 1'b0, 1'b0, B_RF_WR | B_ALU_XOR | B_OPY | B_C_CLR | B_Z_LD, "exor_imm");
        add(5'b00010, 2'b01, 1'b0, 1'b0, B_RF_WR | B_ALU_MOV, "mov_reg");
        add(5'b11001, 2'b10, 1'b0, 1'b0, B_RF_WR | B_RFS_11, "in");
        add(5'b11010, 2'b01, 1'b0, 1'b0, B_IO, "out_1cyc");
        add(5'b11111, 2'b11, 1'b0, 1'b0, B_ILL, "ill_1111111_b");
        add(5'b00000, 2'b00, 1'b0, 1'b0, B_ILL, "ill_0000000");

        @(posedge CLK);
        #1;

        // ---------------- Instance A: reset then decode table ----------------
        cyc_a(B_RST, "a_reset_held");
        a_RESET = 1'b0;
        cyc_a(B_RST, "a_init_once");
        foreach (vecs[i]) begin
            a_HI = vecs[i].hi; a_LO = vecs[i].lo; a_C = vecs[i].c; a_Z = vecs[i].z;
            cyc_a(B_PC_INC, {vecs[i].tag, "_fetch"});
            cyc_a(vecs[i].exp, vecs[i].tag);
        end

        // Interrupt entry after SEI, INT also high in FETCH/INTR (ignored).
        a_HI = 5'b01101; a_LO = 2'b00; a_INT = 1'b1;
        cyc_a(B_PC_INC, "a_int_fetch");
        cyc_a(B_I_SET, "a_sei_int");
        cyc_a(V_INTR, "a_intr");
        a_HI = 5'b01101; a_LO = 2'b11;
        cyc_a(B_PC_INC, "a_fetch_after_intr");
        a_INT = 1'b0;
        cyc_a(V_RETI | B_I_SET, "a_retie");
        cyc_a(B_PC_INC, "a_fetch_after_retie");
        a_RESET = 1'b1;

        // ---------------- Instance B: wait states and stretched strobe --------
        cyc_b(B_RST, "b_reset_held");
        b_RESET = 1'b0;
        cyc_b(B_RST, "b_init_once");
        b_HI = 5'b11011; b_LO = 2'b00;
        fetch_b("b_f_mov");
        cyc_b(B_RF_WR | B_ALU_MOV | B_OPY, "b_mov_imm");

        b_HI = 5'b11010; b_LO = 2'b00; b_INT = 1'b1;
        fetch_b("b_f_out1");
        cyc_b(B_IO, "b_out1_exec");
        cyc_b(B_IO, "b_out1_hold1");
        cyc_b(B_IO, "b_out1_hold2");
        cyc_b(B_IO, "b_out1_hold3");
        cyc_b(V_INTR, "b_out1_intr");
        b_INT = 1'b0;

        // Reset at the second IO_HOLD cycle aborts the strobe.
        fetch_b("b_f_out2");
        cyc_b(B_IO, "b_out2_exec");
        cyc_b(B_IO, "b_out2_hold1");
        b_RESET = 1'b1;
        cyc_b(B_IO, "b_out2_hold2_rst");
        b_RESET = 1'b0;
        cyc_b(B_RST, "b_abort_io_init");

        // Reset in the middle of a fetch wait restarts the wait count.
        cyc_b(B_NONE, "b_f_abort_w0");
        b_RESET = 1'b1;
        cyc_b(B_NONE, "b_f_abort_w1");
        b_RESET = 1'b0;
        cyc_b(B_RST, "b_abort_fetch_init");
        b_HI = 5'b00101; b_LO = 2'b01; b_C = 1'b1;
        fetch_b("b_f_brcc");
        cyc_b(B_NONE, "b_brcc_c1");

        // Stretched strobe with INT low returns to FETCH.
        b_HI = 5'b11010; b_LO = 2'b10;
        fetch_b("b_f_out3");
        cyc_b(B_IO, "b_out3_exec");
        cyc_b(B_IO, "b_out3_hold1");
        cyc_b(B_IO, "b_out3_hold2");
        cyc_b(B_IO, "b_out3_hold3");
        cyc_b(B_NONE, "b_out3_fetch_w0");

        @(negedge CLK);
        n_checks++;
        if ((q_a.size() + q_b.size()) != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", q_a.size() + q_b.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
